// File: rtl/motor_pwm.sv
// motor_pwm: dual-channel slew-limited sign-magnitude PWM stage
// Ports: clk, resetn (sync, active-low); left_frwd/right_back signed 16-bit targets (A/B);
//        pwm_a/pwm_b, dir_a/dir_b registered drive; tick period-end pulse; at_speed both channels settled.
// Option: MOTOR_PWM_DEADTIME_EN clamps zero-crossing ramps to 0 and holds there for 2 extra ticks.
module motor_pwm #(
  parameter int PERIOD = 512,
  parameter int STEP   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] left_frwd,
  input  logic [15:0] right_back,
  output logic        pwm_a,
  output logic        pwm_b,
  output logic        dir_a,
  output logic        dir_b,
  output logic        tick,
  output logic        at_speed
);
  localparam logic [14:0]        LAST = 15'(PERIOD - 1);
  localparam logic [16:0]        FULL = 17'(PERIOD);
  localparam logic signed [16:0] STP  = 17'(STEP);
  logic [14:0] r_cnt, w_cnt_nxt;
  logic        r_tick, r_at_speed;
  logic [15:0] w_tgt [2];
  logic        w_pwm [2];
  logic        w_dir [2];
  logic        w_done [2];
  assign w_tgt[0]  = left_frwd;
  assign w_tgt[1]  = right_back;
  assign w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + 15'd1;
  // tick is registered from the next count so it lines up with cnt == PERIOD-1
  always_ff @(posedge clk)
    if (!resetn) begin
      r_cnt      <= '0;
      r_tick     <= 1'b0;
      r_at_speed <= 1'b1;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (w_cnt_nxt == LAST);
      if (r_tick) r_at_speed <= w_done[0] && w_done[1];
    end
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic signed [15:0] r_cur, w_cur_nxt, w_ramp;
    logic signed [16:0] w_diff;
    logic [16:0]        w_mag;
    logic [15:0]        r_duty;
    logic               r_pwm, r_dir, w_dir_nxt, w_busy;
    // 17-bit difference cannot overflow; the ramp result always fits back in 16 bits
    assign w_diff = $signed({w_tgt[c][15], w_tgt[c]}) - $signed({r_cur[15], r_cur});
    assign w_ramp = 16'((w_diff > STP) ? {r_cur[15], r_cur} + STP :
                        (w_diff < -STP) ? {r_cur[15], r_cur} - STP :
                        {w_tgt[c][15], w_tgt[c]});
`ifdef MOTOR_PWM_DEADTIME_EN
    logic [1:0] r_hold;
    logic       w_cross;
    assign w_cross   = (r_cur != '0) && (w_ramp != '0) && (w_ramp[15] != r_cur[15]);
    assign w_cur_nxt = (r_hold != 2'd0 || w_cross) ? '0 : w_ramp;
    assign w_dir_nxt = (r_hold != 2'd0 || w_cross) ? r_dir : w_ramp[15];
    assign w_busy    = (r_hold > 2'd1) || w_cross;
    always_ff @(posedge clk)
      if (!resetn) r_hold <= '0;
      else if (r_tick) r_hold <= (r_hold != 2'd0) ? r_hold - 2'd1 : (w_cross ? 2'd2 : 2'd0);
`else
    assign w_cur_nxt = w_ramp;
    assign w_dir_nxt = w_ramp[15];
    assign w_busy    = 1'b0;
`endif
    // magnitude of -32768 is 32768, so it needs the 17th bit before clamping
    assign w_mag = w_cur_nxt[15] ? 17'd0 - {1'b1, w_cur_nxt} : {1'b0, w_cur_nxt};
    always_ff @(posedge clk)
      if (!resetn) begin
        r_cur  <= '0;
        r_duty <= '0;
        r_dir  <= 1'b0;
        r_pwm  <= 1'b0;
      end else begin
        r_pwm <= ({1'b0, r_cnt} < r_duty);
        if (r_tick) begin
          r_cur  <= w_cur_nxt;
          r_duty <= (w_mag > FULL) ? FULL[15:0] : w_mag[15:0];
          r_dir  <= w_dir_nxt;
        end
      end
    assign w_pwm[c]  = r_pwm;
    assign w_dir[c]  = r_dir;
    assign w_done[c] = (w_cur_nxt == w_tgt[c]) && !w_busy;
  end
  assign pwm_a    = w_pwm[0];
  assign pwm_b    = w_pwm[1];
  assign dir_a    = w_dir[0];
  assign dir_b    = w_dir[1];
  assign tick     = r_tick;
  assign at_speed = r_at_speed;
endmodule
